// File: rtl/ikascc_wave_step_seq_if.sv
// Register-side / wave-RAM-side signal bundle for one SCC tone sequencer channel.
// master: CPU write decode and observer; slave: the sequencer itself.
interface ikascc_wave_step_seq_if #(
    parameter int unsigned PW = 12,
    parameter int unsigned AW = 5
);
    logic          i_PRD_WR;
    logic [PW-1:0] i_PRD_D;
    logic [1:0]    i_TEST_MODE;
    logic          i_CH_EN;
    logic [AW-1:0] o_ADDR;
    logic          o_STEP;
    logic          o_WRAP;
    logic          o_ACTIVE;

    modport master (
        output i_PRD_WR, i_PRD_D, i_TEST_MODE, i_CH_EN,
        input  o_ADDR, o_STEP, o_WRAP, o_ACTIVE
    );

    modport slave (
        input  i_PRD_WR, i_PRD_D, i_TEST_MODE, i_CH_EN,
        output o_ADDR, o_STEP, o_WRAP, o_ACTIVE
    );
endinterface

// File: rtl/ikascc_wave_step_seq.sv
// Per-channel SCC tone sequencer: period latch, period down-counter and 5-bit
// wave-RAM address stepper. Optional build macro IKASCC_WAVE_RESET_ON_PRD_WRITE_EN
// makes a period write restart the counter and rewind the wave address to 0.
module ikascc_wave_step_seq #(
    parameter int unsigned PW       = 12,
    parameter int unsigned AW       = 5,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_RST,
    input  logic                    i_MCLK_PCEN_n,
    ikascc_wave_step_seq_if.slave   bus
);
    typedef enum logic {StHold, StRun} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] prd_q, prd_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;

    logic          en;
    logic          hold;
    logic [PW-1:0] ep;
    logic [PW-1:0] ep_reload;

    // Test mode hides upper period bits; hidden bits read as zero.
    function automatic logic [PW-1:0] mask_ep(input logic [PW-1:0] v, input logic [1:0] mode);
        logic [PW-1:0] m;
        case (mode)
            2'b01:   m = PW'(8'hFF);
            2'b10:   m = PW'(4'hF);
            default: m = '1;
        endcase
        return v & m;
    endfunction

    // Effective period, hold decision, and write-bypassed reload value.
    always_comb begin
        en        = ~i_MCLK_PCEN_n;
        ep        = mask_ep(prd_q, bus.i_TEST_MODE);
        ep_reload = mask_ep(bus.i_PRD_WR ? bus.i_PRD_D : prd_q, bus.i_TEST_MODE);
        hold      = (ep <= PW'(HOLD_MAX)) || !bus.i_CH_EN;
    end

    // Next-state logic for FSM, counter, address and step/wrap pulses.
    always_comb begin
        state_d = state_q;
        prd_d   = prd_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        step_d  = step_q;
        wrap_d  = wrap_q;
        if (en) begin
            if (bus.i_PRD_WR) prd_d = bus.i_PRD_D;
            step_d = 1'b0;
            wrap_d = 1'b0;
            if (hold) begin
                state_d = StHold;
                cnt_d   = ep;
            end else if (state_q == StHold) begin
                state_d = StRun;
                cnt_d   = ep;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                // Borrow: reload (sees a same-cycle write) and advance.
                cnt_d  = ep_reload;
                addr_d = addr_q + 1'b1;
                step_d = 1'b1;
                wrap_d = (addr_q == '1);
            end
`ifdef IKASCC_WAVE_RESET_ON_PRD_WRITE_EN
            // A write restarts the waveform and wins over a coincident borrow.
            if (bus.i_PRD_WR) begin
                cnt_d  = ep_reload;
                addr_d = '0;
                step_d = 1'b0;
                wrap_d = 1'b0;
            end
`endif
        end
    end

    // State registers; reset ignores the clock enable.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q <= StHold;
            prd_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prd_q   <= prd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_ADDR   = addr_q;
    assign bus.o_STEP   = step_q;
    assign bus.o_WRAP   = wrap_q;
    assign bus.o_ACTIVE = (state_q == StRun);
endmodule

// File: tb/tb_ikascc_wave_step_seq.sv
// Directed self-checking bench for ikascc_wave_step_seq.
// Observed word packing: {active, wrap, step, addr[4:0]}.
module tb_ikascc_wave_step_seq;
    localparam int unsigned PW = 12;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic pcen_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    ikascc_wave_step_seq_if #(.PW(PW), .AW(AW)) bus ();

    ikascc_wave_step_seq #(.PW(PW), .AW(AW), .HOLD_MAX(8)) dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_MCLK_PCEN_n (pcen_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {24'd0, bus.o_ACTIVE, bus.o_WRAP, bus.o_STEP, bus.o_ADDR};
    endfunction

    function automatic logic [31:0] pk(input logic a, input logic w, input logic s,
                                       input logic [4:0] ad);
        return {24'd0, a, w, s, ad};
    endfunction

    // One disabled clock followed by one enabled clock (PCEN every 2nd clock).
    task automatic en_cycle();
        pcen_n = 1'b1;
        @(posedge clk); #1;
        pcen_n = 1'b0;
        @(posedge clk); #1;
        pcen_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) en_cycle();
    endtask

    task automatic run_count(input int n, output int steps);
        steps = 0;
        for (int i = 0; i < n; i++) begin
            en_cycle();
            if (bus.o_STEP) steps++;
        end
    endtask

    task automatic wr(input logic [11:0] d);
        bus.i_PRD_WR = 1'b1;
        bus.i_PRD_D  = d;
        en_cycle();
        bus.i_PRD_WR = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pcen_n = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        bus.i_TEST_MODE = 2'b00;
        bus.i_CH_EN     = 1'b1;
    endtask

    initial begin
        int         n_steps;
        logic       s;
        logic [4:0] a;

        rst = 1'b1; pcen_n = 1'b1;
        bus.i_PRD_WR = 1'b0; bus.i_PRD_D = '0; bus.i_TEST_MODE = 2'b00; bus.i_CH_EN = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("reset_state", obs(), pk(0, 0, 0, 0));

        // Reset in the middle of RUN, with clock enable inactive.
        wr(12'h00A);
        run(30);
        check_val("a_before_reset", obs(), pk(1, 0, 0, 2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("a_reset_mid_run", obs(), pk(0, 0, 0, 0));
        run(5);
        check_val("a_latch_cleared", obs(), pk(0, 0, 0, 0));

        // Normal stepping, EP = 9: step every 10 enabled cycles, wrap at 320.
        do_reset();
        wr(12'h009);
        for (int i = 1; i <= 330; i++) begin
            en_cycle();
            s = (i >= 11) && ((i - 1) % 10 == 0);
            a = (i >= 11) ? 5'(((i - 1) / 10) % 32) : 5'd0;
            check_val($sformatf("b_cyc%0d", i), obs(), pk(1, s && (a == 5'd0), s, a));
        end

        // Mode 01: 0x10A -> EP = 0x0A, step every 11 enabled cycles.
        do_reset();
        bus.i_TEST_MODE = 2'b01;
        wr(12'h10A);
        for (int i = 1; i <= 25; i++) begin
            en_cycle();
            s = (i >= 12) && ((i - 1) % 11 == 0);
            a = (i >= 12) ? 5'((i - 1) / 11) : 5'd0;
            check_val($sformatf("c_cyc%0d", i), obs(), pk(1, 1'b0, s, a));
        end
        // Mode 10: 0x0F5 -> EP = 5 -> HOLD on the following enabled cycle.
        bus.i_TEST_MODE = 2'b10;
        wr(12'h0F5);
`ifdef IKASCC_WAVE_RESET_ON_PRD_WRITE_EN
        check_val("c_mode10_write", obs(), pk(1, 0, 0, 0));
        en_cycle();
        check_val("c_mode10_hold", obs(), pk(0, 0, 0, 0));
        run(20);
        check_val("c_mode10_frozen", obs(), pk(0, 0, 0, 0));
`else
        check_val("c_mode10_write", obs(), pk(1, 0, 0, 2));
        en_cycle();
        check_val("c_mode10_hold", obs(), pk(0, 0, 0, 2));
        run(20);
        check_val("c_mode10_frozen", obs(), pk(0, 0, 0, 2));
`endif

        // Hold threshold: 8 holds, 9 runs.
        do_reset();
        wr(12'h008);
        run_count(100, n_steps);
        check_val("d_steps_ep8", n_steps, 0);
        check_val("d_ep8_state", obs(), pk(0, 0, 0, 0));
        wr(12'h009);
        check_val("d_ep9_write", obs(), pk(0, 0, 0, 0));
        en_cycle();
        check_val("d_ep9_active", obs(), pk(1, 0, 0, 0));
        run_count(9, n_steps);
        check_val("d_ep9_no_early_step", n_steps, 0);
        en_cycle();
        check_val("d_ep9_first_step", obs(), pk(1, 0, 1, 1));

        // Write/borrow collision: 0x010 then write 0x020 on the borrow cycle.
        do_reset();
        wr(12'h010);
        run(17);
        check_val("e_pre_borrow", obs(), pk(1, 0, 0, 0));
        wr(12'h020);
`ifdef IKASCC_WAVE_RESET_ON_PRD_WRITE_EN
        check_val("e_borrow_write", obs(), pk(1, 0, 0, 0));
`else
        check_val("e_borrow_write", obs(), pk(1, 0, 1, 1));
`endif
        run_count(32, n_steps);
        check_val("e_interval_no_step", n_steps, 0);
        en_cycle();
`ifdef IKASCC_WAVE_RESET_ON_PRD_WRITE_EN
        check_val("e_step_after_33", obs(), pk(1, 0, 1, 1));
`else
        check_val("e_step_after_33", obs(), pk(1, 0, 1, 2));
`endif

        // Enable gating: writes with clock enable off are ignored.
        do_reset();
        wr(12'h00A);
        run(12);
        check_val("f_first_step", obs(), pk(1, 0, 1, 1));
        bus.i_PRD_D = 12'h020;
        for (int i = 0; i < 50; i++) begin
            pcen_n       = 1'b1;
            bus.i_PRD_WR = (i % 2 == 0);
            @(posedge clk); #1;
        end
        bus.i_PRD_WR = 1'b0;
        check_val("f_gated_hold", obs(), pk(1, 0, 1, 1));
        run(11);
        check_val("f_counter_kept", obs(), pk(1, 0, 1, 2));
        run(11);
        check_val("f_latch_kept", obs(), pk(1, 0, 1, 3));
        bus.i_CH_EN = 1'b0;
        en_cycle();
        check_val("f_ch_dis", obs(), pk(0, 0, 0, 3));
        run(5);
        check_val("f_ch_dis_frozen", obs(), pk(0, 0, 0, 3));
        bus.i_CH_EN = 1'b1;
        run_count(11, n_steps);
        check_val("f_reen_no_early_step", n_steps, 0);
        check_val("f_reen_state", obs(), pk(1, 0, 0, 3));
        en_cycle();
        check_val("f_reen_step", obs(), pk(1, 0, 1, 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
